ahb_to_avalon_bridge: RTL
=========================

Name: ahb_to_avalon_bridge

Overview:
- AHB-Lite slave-side bridge that sits directly downstream of the AHB master model and consumes its single transfers: NONSEQ address phase, then data phase.
- Converts each transfer into exactly one Avalon-MM master read or write, handling waitrequest and variable-latency readdatavalid.
- Stretches the AHB data phase with hready low until the Avalon side completes.
- Lets the existing AHB master model drive Avalon slave IP in the library.

Parameters:
- DW, 32, data width for hwdata/hrdata/avm data; only 32 is supported.
- AW, 32, address width for both sides; byte addresses.

Ports:
- hclk  in  1  single clock for both sides
- hreset  in  1  reset; one clock; reset is synchronous and active-high
- haddr  in  AW  AHB address, valid in the address phase
- htrans  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11
- hsize  in  3  0=byte, 1=half, 2=word
- hwrite  in  1  1=write, valid in the address phase
- hwdata  in  DW  write data, valid in the data phase (cycle after address)
- hrdata  out  DW  read data, valid when hready=1 ends a read data phase
- hready  out  1  data-phase done / address-phase accept
- avm_address  out  AW  word-aligned byte address (haddr with [1:0]=0)
- avm_read  out  1  Avalon read request
- avm_write  out  1  Avalon write request
- avm_writedata  out  DW  write data
- avm_byteenable  out  DW/8  lane enables
- avm_readdata  in  DW  read data
- avm_readdatavalid  in  1  read data valid
- avm_waitrequest  in  1  Avalon stall

Behaviour:
- Reset (sync, hreset=1 at posedge) forces the following from the next cycle, whatever the state, including mid-transfer:
  - state=IDLE, hready=1, hrdata=0;
  - avm_read=0, avm_write=0, avm_address=0, avm_writedata=0, avm_byteenable=0.
- After a reset mid-transfer, a pending Avalon request is dropped (no further assertion) and a late readdatavalid is ignored.
- All outputs are registered.
- State machine:
  - IDLE: hready=1. At a posedge with htrans[1]=1 and hready=1, latch haddr/hsize/hwrite.
    - Compute the byte enable and go to W_DATA if hwrite=1, else to R_REQ with avm_read=1.
    - htrans IDLE/BUSY: no action.
  - W_DATA: hready=0. Capture hwdata into avm_writedata, assert avm_write=1, go to W_REQ.
  - W_REQ: hold avm_write/address/data/byteenable stable while avm_waitrequest=1.
    - On a posedge with avm_waitrequest=0: deassert avm_write, hready=1, go to IDLE.
  - R_REQ: hold avm_read while avm_waitrequest=1.
    - On acceptance: deassert avm_read.
    - If avm_readdatavalid is also 1 in that cycle: hrdata<=avm_readdata, hready=1, go to IDLE.
    - Otherwise go to R_WAIT.
  - R_WAIT: hready=0. On avm_readdatavalid=1: hrdata<=avm_readdata, hready=1, go to IDLE.
- Pipelining: the hready=1 cycle that ends a data phase is also the IDLE sample cycle, so back-to-back transfers are accepted.
- Minimum write latency is 3 cycles from address phase to hready high with zero waitrequest.
- Minimum read latency is 2 cycles.
- Byte enable:
  - hsize=0: 4'b0001 << haddr[1:0].
  - hsize=1: 4'b0011 << {haddr[1],1'b0} (haddr[0] ignored).
  - hsize>=2: 4'b1111.
- Data is not lane-shifted; AHB data is already lane-placed.
- hrdata holds its last value until the next read completes.
- readdatavalid outside R_REQ/R_WAIT is ignored.
- waitrequest is ignored when no request is asserted.

Decomposition:
- Package ahb_avalon_pkg:
  - HTRANS constants (AHB_IDLE/BUSY/NONSEQ/SEQ);
  - HSIZE constants;
  - FSM state encoding (IDLE, W_DATA, W_REQ, R_REQ, R_WAIT).
- One sub-module, ahb_byteenable_gen: combinational hsize + haddr[1:0] -> byteenable[3:0].

Test Plan:
- Write 0xDEADBEEF to 0x0000_0010, hsize=2, waitrequest=0 -> one avm_write pulse with address 0x10, byteenable 4'hF, writedata 0xDEADBEEF; hready low 2 cycles then high.
- Write byte to 0x13 (hsize=0) with waitrequest held 3 cycles -> avm_address 0x10, byteenable 4'b1000, avm_write held 4 cycles, fields stable throughout.
- Read 0x20, slave returns 0x12345678 with readdatavalid 4 cycles after acceptance -> hready low until then, hrdata=0x12345678 when hready rises; master reads 0x12345678.
- Read with readdatavalid in the same cycle as acceptance -> R_WAIT skipped, 2-cycle read.
- Back-to-back write 0x4→0xA5 then read 0x4 from a simple memory slave -> read returns 0x000000A5, second address captured on the completing hready cycle.
- Assert hreset during W_REQ with waitrequest=1 -> next cycle avm_write=0, hready=1, state IDLE; a subsequent read completes normally.

Source files
------------

// File: rtl/ahb_avalon_pkg.sv
// Shared constants for the AHB-Lite to Avalon-MM bridge: transfer types,
// transfer sizes and the bridge FSM state encoding.
package ahb_avalon_pkg;

    // AHB htrans encodings
    localparam logic [1:0] AHB_IDLE   = 2'b00;
    localparam logic [1:0] AHB_BUSY   = 2'b01;
    localparam logic [1:0] AHB_NONSEQ = 2'b10;
    localparam logic [1:0] AHB_SEQ    = 2'b11;

    // AHB hsize encodings (anything wider than a word is treated as a word)
    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    // Bridge FSM states
    typedef enum logic [2:0] {
        IDLE,
        W_DATA,
        W_REQ,
        R_REQ,
        R_WAIT
    } state_t;

    // A transfer is started only by NONSEQ or SEQ; IDLE and BUSY carry no request
    function automatic logic htrans_active(input logic [1:0] t);
        htrans_active = 1'b0;
        case (t)
            AHB_NONSEQ, AHB_SEQ: htrans_active = 1'b1;
            AHB_IDLE, AHB_BUSY:  htrans_active = 1'b0;
            default:             htrans_active = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ahb_to_avalon_bridge_if.sv
// Bus bundle joining the AHB-Lite master side and the Avalon-MM slave side.
// The bridge uses the slave modport; the driving environment uses master.
interface ahb_to_avalon_bridge_if #(
    parameter int DW = 32,
    parameter int AW = 32
);
    // AHB-Lite side
    logic [AW-1:0]   haddr;
    logic [1:0]      htrans;
    logic [2:0]      hsize;
    logic            hwrite;
    logic [DW-1:0]   hwdata;
    logic [DW-1:0]   hrdata;
    logic            hready;

    // Avalon-MM side
    logic [AW-1:0]   avm_address;
    logic            avm_read;
    logic            avm_write;
    logic [DW-1:0]   avm_writedata;
    logic [DW/8-1:0] avm_byteenable;
    logic [DW-1:0]   avm_readdata;
    logic            avm_readdatavalid;
    logic            avm_waitrequest;

    modport slave (
        input  haddr, htrans, hsize, hwrite, hwdata,
        output hrdata, hready,
        output avm_address, avm_read, avm_write, avm_writedata, avm_byteenable,
        input  avm_readdata, avm_readdatavalid, avm_waitrequest
    );

    modport master (
        output haddr, htrans, hsize, hwrite, hwdata,
        input  hrdata, hready,
        input  avm_address, avm_read, avm_write, avm_writedata, avm_byteenable,
        output avm_readdata, avm_readdatavalid, avm_waitrequest
    );
endinterface

// File: rtl/ahb_byteenable_gen.sv
// Combinational Avalon byte-enable decode from AHB hsize and the low
// address bits. Data is already lane-placed, so only the lanes move.
module ahb_byteenable_gen
    import ahb_avalon_pkg::*;
(
    input  logic [2:0] i_hsize,
    input  logic [1:0] i_addr_lo,
    output logic [3:0] o_byteenable
);

    // Select the active lanes for byte, halfword and word transfers
    always_comb begin
        // NOTE: a default before the case keeps every path assigned, so no latch is inferred.
        o_byteenable = 4'hF;
        case (i_hsize)
            HSIZE_BYTE: o_byteenable = 4'b0001 << i_addr_lo;
            HSIZE_HALF: o_byteenable = 4'b0011 << {i_addr_lo[1], 1'b0};
            HSIZE_WORD: o_byteenable = 4'hF;
            default:    o_byteenable = 4'hF;
        endcase
    end

endmodule

// File: rtl/ahb_to_avalon_bridge.sv
// AHB-Lite single-transfer slave that turns each NONSEQ/SEQ transfer into
// exactly one Avalon-MM read or write, stretching the AHB data phase with
// hready low until the Avalon side has finished. All outputs are registered.
module ahb_to_avalon_bridge
    import ahb_avalon_pkg::*;
#(
    parameter int DW = 32,
    parameter int AW = 32
) (
    input logic                    hclk,
    input logic                    hreset,
    ahb_to_avalon_bridge_if.slave  bus
);

    state_t          r_state;
    logic            r_hready;
    logic [DW-1:0]   r_hrdata;
    logic [AW-1:0]   r_avm_address;
    logic            r_avm_read;
    logic            r_avm_write;
    logic [DW-1:0]   r_avm_writedata;
    logic [DW/8-1:0] r_avm_byteenable;
    logic [3:0]      w_byteenable;

    ahb_byteenable_gen u_be_gen (
        .i_hsize      (bus.hsize),
        .i_addr_lo    (bus.haddr[1:0]),
        .o_byteenable (w_byteenable)
    );

    // Transfer sequencing: address accept, Avalon request and data-phase completion
    always_ff @(posedge hclk) begin
        // NOTE: all state here uses non-blocking assignment so every register samples pre-edge values.
        if (hreset) begin
            r_state          <= IDLE;
            r_hready         <= 1'b1;
            r_hrdata         <= '0;
            r_avm_address    <= '0;
            r_avm_read       <= 1'b0;
            r_avm_write      <= 1'b0;
            r_avm_writedata  <= '0;
            r_avm_byteenable <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (htrans_active(bus.htrans) && r_hready) begin
                        r_avm_address    <= {bus.haddr[AW-1:2], 2'b00};
                        r_avm_byteenable <= w_byteenable;
                        r_hready         <= 1'b0;
                        if (bus.hwrite) begin
                            r_state <= W_DATA;
                        end else begin
                            r_avm_read <= 1'b1;
                            r_state    <= R_REQ;
                        end
                    end
                end
                W_DATA: begin
                    // hwdata is valid now, one cycle after the address phase
                    r_avm_writedata <= bus.hwdata;
                    r_avm_write     <= 1'b1;
                    r_state         <= W_REQ;
                end
                W_REQ: begin
                    if (!bus.avm_waitrequest) begin
                        r_avm_write <= 1'b0;
                        r_hready    <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                R_REQ: begin
                    if (!bus.avm_waitrequest) begin
                        r_avm_read <= 1'b0;
                        // Zero-latency slaves return data in the accepting cycle
                        if (bus.avm_readdatavalid) begin
                            r_hrdata <= bus.avm_readdata;
                            r_hready <= 1'b1;
                            r_state  <= IDLE;
                        end else begin
                            r_state  <= R_WAIT;
                        end
                    end
                end
                R_WAIT: begin
                    if (bus.avm_readdatavalid) begin
                        r_hrdata <= bus.avm_readdata;
                        r_hready <= 1'b1;
                        r_state  <= IDLE;
                    end
                end
                default: begin
                    r_state  <= IDLE;
                    r_hready <= 1'b1;
                end
            endcase
        end
    end

    assign bus.hready         = r_hready;
    assign bus.hrdata         = r_hrdata;
    assign bus.avm_address    = r_avm_address;
    assign bus.avm_read       = r_avm_read;
    assign bus.avm_write      = r_avm_write;
    assign bus.avm_writedata  = r_avm_writedata;
    assign bus.avm_byteenable = r_avm_byteenable;

endmodule
